// File: rtl/pc_call_stack.sv
// Registered program counter with jump, branch, call and return, backed by a small
// LIFO return-address stack with sticky overflow/underflow flags.
module pc_call_stack #(
  parameter int unsigned         ADDR_W      = 8,
  parameter int unsigned         STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]   RESET_ADDR  = '0,
  localparam int unsigned        DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Stall,
  input  logic [2:0]         i_Op,
  input  logic [ADDR_W-1:0]  i_Target,
  input  logic [ADDR_W-1:0]  i_Offset,
  input  logic               i_Cond,
  output logic [ADDR_W-1:0]  o_PC,
  output logic [ADDR_W-1:0]  o_Ret_Top,
  output logic [DEPTH_W-1:0] o_Depth,
  output logic               o_Overflow,
  output logic               o_Underflow
);

  localparam int unsigned        IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] Full  = DEPTH_W'(STACK_DEPTH);

  localparam logic [2:0] OpJmp  = 3'b001;
  localparam logic [2:0] OpBrc  = 3'b010;
  localparam logic [2:0] OpBrr  = 3'b011;
  localparam logic [2:0] OpCall = 3'b100;
  localparam logic [2:0] OpRet  = 3'b101;
  localparam logic [2:0] OpHold = 3'b110;

  logic [ADDR_W-1:0]  r_Pc;
  logic [DEPTH_W-1:0] r_Depth;
  logic               r_Overflow;
  logic               r_Underflow;
  logic [ADDR_W-1:0]  r_Stack [STACK_DEPTH];

  logic [ADDR_W-1:0]  w_Pc_Inc;
  logic [ADDR_W-1:0]  w_Pc_Next;
  logic [IDX_W-1:0]   w_Top_Idx;
  logic [IDX_W-1:0]   w_Push_Idx;
  logic               w_Push;
  logic               w_Pop;
  logic               w_Ovf_Set;
  logic               w_Unf_Set;

  assign w_Pc_Inc   = r_Pc + ADDR_W'(1);
  assign w_Top_Idx  = IDX_W'(r_Depth - DEPTH_W'(1));
  assign w_Push_Idx = IDX_W'(r_Depth);

  always_comb begin
    w_Pc_Next = w_Pc_Inc;
    w_Push    = 1'b0;
    w_Pop     = 1'b0;
    w_Ovf_Set = 1'b0;
    w_Unf_Set = 1'b0;
    case (i_Op)
      OpJmp:  w_Pc_Next = i_Target;
      OpBrc:  if (i_Cond) w_Pc_Next = i_Target;
      // Unsigned add of equal widths wraps exactly like a sign-extended add truncated.
      OpBrr:  if (i_Cond) w_Pc_Next = r_Pc + i_Offset;
      OpCall: begin
        if (r_Depth < Full) begin
          w_Push    = 1'b1;
          w_Pc_Next = i_Target;
        end else begin
          w_Ovf_Set = 1'b1;
        end
      end
      OpRet: begin
        if (r_Depth != '0) begin
          w_Pop     = 1'b1;
          w_Pc_Next = r_Stack[w_Top_Idx];
        end else begin
          w_Unf_Set = 1'b1;
        end
      end
      OpHold:  w_Pc_Next = r_Pc;
      default: w_Pc_Next = w_Pc_Inc;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Pc        <= RESET_ADDR;
      r_Depth     <= '0;
      r_Overflow  <= 1'b0;
      r_Underflow <= 1'b0;
    end else if (!i_Stall) begin
      r_Pc        <= w_Pc_Next;
      r_Overflow  <= r_Overflow | w_Ovf_Set;
      r_Underflow <= r_Underflow | w_Unf_Set;
      if (w_Push) begin
        r_Depth <= r_Depth + DEPTH_W'(1);
      end else if (w_Pop) begin
        r_Depth <= r_Depth - DEPTH_W'(1);
      end
    end
  end

  // Entries are not cleared on reset; the depth gate on o_Ret_Top hides stale data.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst && !i_Stall && w_Push) begin
      r_Stack[w_Push_Idx] <= w_Pc_Inc;
    end
  end

  assign o_PC        = r_Pc;
  assign o_Depth     = r_Depth;
  assign o_Overflow  = r_Overflow;
  assign o_Underflow = r_Underflow;
  assign o_Ret_Top   = (r_Depth == '0) ? '0 : r_Stack[w_Top_Idx];

endmodule

// File: tb/tb_pc_call_stack.sv
// Randomized and directed bench for pc_call_stack, checked against a queue-based
// reference model of the program counter and return stack.
module tb_pc_call_stack;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst, stall, cond;
  logic [2:0] op;
  logic [7:0] tgt, off;
  logic [7:0] pc, ret_top;
  logic [2:0] depth;
  logic       ovf, unf;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_call_stack #(
    .ADDR_W     (ADDR_W),
    .STACK_DEPTH(DEPTH),
    .RESET_ADDR (8'h00)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Stall    (stall),
    .i_Op       (op),
    .i_Target   (tgt),
    .i_Offset   (off),
    .i_Cond     (cond),
    .o_PC       (pc),
    .o_Ret_Top  (ret_top),
    .o_Depth    (depth),
    .o_Overflow (ovf),
    .o_Underflow(unf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input int o, input int t, input int f, input bit c,
                              input bit s, input bit r);
    int nxt;
    nxt = (m_pc + 1) % 256;
    if (r) begin
      m_pc = 0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (!s) begin
      case (o)
        1: m_pc = t;
        2: m_pc = c ? t : nxt;
        3: m_pc = c ? ((m_pc + ((f >= 128) ? f - 256 : f)) % 256 + 256) % 256 : nxt;
        4: begin
          if (m_stk.size() < DEPTH) begin
            m_stk.push_back(nxt);
            m_pc = t;
          end else begin
            m_ovf = 1;
            m_pc  = nxt;
          end
        end
        5: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_unf = 1;
            m_pc  = nxt;
          end
        end
        6: m_pc = m_pc;
        default: m_pc = nxt;
      endcase
    end
  endtask

  // Apply one op at the falling edge, clock it, then compare everything at the next fall.
  task automatic step(input logic [2:0] o, input logic [7:0] t, input logic [7:0] f,
                      input logic c, input logic s, input logic r);
    op = o; tgt = t; off = f; cond = c; stall = s; rst = r;
    model_update(int'(o), int'(t), int'(f), c, s, r);
    @(posedge clk);
    @(negedge clk);
    check_eq("pc", 32'(pc), 32'(m_pc));
    check_eq("depth", 32'(depth), 32'(m_stk.size()));
    check_eq("ret_top", 32'(ret_top), (m_stk.size() > 0) ? 32'(m_stk[$]) : 32'd0);
    check_eq("overflow", 32'(ovf), 32'(m_ovf));
    check_eq("underflow", 32'(unf), 32'(m_unf));
  endtask

  initial begin
    op = 3'd0; tgt = '0; off = '0; cond = 1'b0; stall = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset state and underflow on an empty stack
    step(3'd0, 8'h00, 8'h00, 0, 0, 1);
    check_eq("rst_pc", 32'(pc), 32'h00);
    check_eq("rst_depth", 32'(depth), 32'd0);
    step(3'd5, 8'h00, 8'h00, 0, 0, 0);
    check_eq("unf_pc", 32'(pc), 32'h01);
    check_eq("unf_flag", 32'(unf), 32'd1);
    check_eq("unf_top", 32'(ret_top), 32'd0);

    // Wrap on INC and on a negative relative branch
    step(3'd0, 8'h00, 8'h00, 0, 0, 1);
    step(3'd1, 8'hFF, 8'h00, 0, 0, 0);
    step(3'd0, 8'h00, 8'h00, 0, 0, 0);
    check_eq("inc_wrap", 32'(pc), 32'h00);
    step(3'd1, 8'h02, 8'h00, 0, 0, 0);
    step(3'd3, 8'h00, 8'hFC, 1, 0, 0);
    check_eq("brr_wrap", 32'(pc), 32'hFE);

    // Nested call/return
    step(3'd1, 8'h0A, 8'h00, 0, 0, 0);
    step(3'd4, 8'h40, 8'h00, 0, 0, 0);
    check_eq("nest_pc1", 32'(pc), 32'h40);
    step(3'd4, 8'h80, 8'h00, 0, 0, 0);
    check_eq("nest_pc2", 32'(pc), 32'h80);
    check_eq("nest_d2", 32'(depth), 32'd2);
    step(3'd5, 8'h00, 8'h00, 0, 0, 0);
    check_eq("nest_pc3", 32'(pc), 32'h41);
    step(3'd5, 8'h00, 8'h00, 0, 0, 0);
    check_eq("nest_pc4", 32'(pc), 32'h0B);
    check_eq("nest_d0", 32'(depth), 32'd0);

    // Overflow on the fifth CALL; flag survives later RETs
    step(3'd0, 8'h00, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(3'd4, 8'h20, 8'h00, 0, 0, 0);
    check_eq("ovf_pc", 32'(pc), 32'h21);
    check_eq("ovf_depth", 32'(depth), 32'd4);
    check_eq("ovf_flag", 32'(ovf), 32'd1);
    step(3'd5, 8'h00, 8'h00, 0, 0, 0);
    step(3'd5, 8'h00, 8'h00, 0, 0, 0);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);

    // Stall over CALL, and a not-taken conditional branch
    step(3'd0, 8'h00, 8'h00, 0, 0, 1);
    step(3'd1, 8'h05, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(3'd4, 8'h77, 8'h00, 0, 1, 0);
    check_eq("stall_pc", 32'(pc), 32'h05);
    check_eq("stall_depth", 32'(depth), 32'd0);
    step(3'd2, 8'h99, 8'h00, 0, 0, 0);
    check_eq("brc_nt", 32'(pc), 32'h06);

    // Reset coinciding with a CALL at depth 2 clears everything
    step(3'd0, 8'h00, 8'h00, 0, 0, 1);
    step(3'd5, 8'h00, 8'h00, 0, 0, 0);
    step(3'd4, 8'h30, 8'h00, 0, 0, 0);
    step(3'd4, 8'h50, 8'h00, 0, 0, 0);
    step(3'd4, 8'h70, 8'h00, 0, 0, 1);
    check_eq("rmid_pc", 32'(pc), 32'h00);
    check_eq("rmid_depth", 32'(depth), 32'd0);
    check_eq("rmid_unf", 32'(unf), 32'd0);

    // Randomized traffic, biased toward CALL/RET so the stack fills and drains
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] r_op;
      r_op = ($urandom_range(0, 2) == 0) ? 3'(4 + $urandom_range(0, 1)) : 3'($urandom);
      step(r_op, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
